// File: rtl/quad_decoder_counter.sv
// Quadrature A/B decoder (x4) feeding a WIDTH-bit up/down position counter.
// Optional per-channel glitch filter is enabled by defining QDEC_FILTER_EN.
module quad_decoder_counter #(
   parameter int WIDTH      = 16,
   parameter int FILTER_LEN = 4
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             ce,
   input  logic             a_in,
   input  logic             b_in,
   input  logic             load,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q,
   output logic             dir,
   output logic             step,
   output logic             wrap,
   output logic             err
);

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   logic [1:0] raw;
   logic [1:0] phase;

   assign raw = {a_in, b_in};

   // Channel 1 is phase A, channel 0 is phase B, so phase = {A,B}.
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_chan
         logic sync1_reg;
         logic sync2_reg;

         always_ff @(posedge clk) begin
            if (clr) begin
               sync1_reg <= 1'b0;
               sync2_reg <= 1'b0;
            end else begin
               sync1_reg <= raw[gi];
               sync2_reg <= sync1_reg;
            end
         end

`ifdef QDEC_FILTER_EN
         localparam int CW = $clog2(FILTER_LEN + 1);
         logic [CW-1:0] cnt_reg;
         logic          filt_reg;

         // Counts consecutive samples that disagree with the accepted level.
         always_ff @(posedge clk) begin
            if (clr) begin
               cnt_reg  <= '0;
               filt_reg <= 1'b0;
            end else if (sync2_reg != filt_reg) begin
               if (cnt_reg == CW'(FILTER_LEN - 1)) begin
                  filt_reg <= sync2_reg;
                  cnt_reg  <= '0;
               end else begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
            end else begin
               cnt_reg <= '0;
            end
         end

         assign phase[gi] = filt_reg;
`else
         assign phase[gi] = sync2_reg;
`endif
      end
   endgenerate

   logic [1:0]       prev_reg;
   logic             primed_reg;
   logic             changed;
   logic             illegal;
   logic             valid_step;
   logic             up;
   logic             at_edge;
   logic [WIDTH-1:0] q_next;

   // Up order is 00->10->11->01: new A always differs from old B when moving up.
   always_comb begin
      changed    = primed_reg && (prev_reg != phase);
      illegal    = primed_reg && ((prev_reg ^ phase) == 2'b11);
      valid_step = changed && !illegal;
      up         = phase[1] ^ prev_reg[0];
      q_next     = up ? (q + ONE) : (q - ONE);
      at_edge    = up ? (&q) : (q == '0);
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         prev_reg   <= 2'b00;
         primed_reg <= 1'b0;
         q          <= '0;
         dir        <= 1'b0;
         step       <= 1'b0;
         wrap       <= 1'b0;
         err        <= 1'b0;
      end else begin
         primed_reg <= 1'b1;
         prev_reg   <= phase;
         step       <= 1'b0;
         wrap       <= 1'b0;
         err        <= illegal;
         if (load) begin
            q <= d;
         end else if (valid_step && ce) begin
            q    <= q_next;
            dir  <= up;
            step <= 1'b1;
            wrap <= at_edge;
         end
      end
   end

endmodule

// File: tb/tb_quad_decoder_counter.sv
// Directed self-checking bench for quad_decoder_counter; define QDEC_FILTER_EN
// to also exercise the glitch filter.
module tb_quad_decoder_counter;

   localparam int W  = 16;
   localparam int FL = 4;
`ifdef QDEC_FILTER_EN
   localparam int LAT  = FL + 2;
   localparam int FAST = FL + 1;
`else
   localparam int LAT  = 2;
   localparam int FAST = 1;
`endif

   logic         clk;
   logic         clr;
   logic         ce;
   logic         a_in;
   logic         b_in;
   logic         load;
   logic [W-1:0] d;
   logic [W-1:0] q;
   logic         dir;
   logic         step;
   logic         wrap;
   logic         err;

   int total_cnt = 0;
   int pass_cnt  = 0;
   int step_cnt  = 0;
   int wrap_cnt  = 0;
   int err_cnt   = 0;

   quad_decoder_counter #(.WIDTH(W), .FILTER_LEN(FL)) dut (
      .clk  (clk),
      .clr  (clr),
      .ce   (ce),
      .a_in (a_in),
      .b_in (b_in),
      .load (load),
      .d    (d),
      .q    (q),
      .dir  (dir),
      .step (step),
      .wrap (wrap),
      .err  (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance n cycles, sampling pulses on the falling edge.
   task automatic tick(input int n);
      repeat (n) begin
         @(negedge clk);
         if (step === 1'b1) step_cnt++;
         if (wrap === 1'b1) wrap_cnt++;
         if (err === 1'b1) err_cnt++;
      end
   endtask

   task automatic drive(input logic [1:0] s, input int n);
      a_in = s[1];
      b_in = s[0];
      tick(n);
   endtask

   task automatic clear_counts();
      step_cnt = 0;
      wrap_cnt = 0;
      err_cnt  = 0;
   endtask

   task automatic test_reset();
      clr = 1'b1; ce = 1'b0; load = 1'b0; d = '0; a_in = 1'b0; b_in = 1'b0;
      tick(2);
      total_cnt++; if (q !== 16'h0000) $display("FAIL reset_q got=%h exp=0000", q); else pass_cnt++;
      total_cnt++; if (dir !== 1'b0) $display("FAIL reset_dir got=%b exp=0", dir); else pass_cnt++;
      total_cnt++; if (step !== 1'b0) $display("FAIL reset_step got=%b exp=0", step); else pass_cnt++;
      total_cnt++; if (wrap !== 1'b0) $display("FAIL reset_wrap got=%b exp=0", wrap); else pass_cnt++;
      total_cnt++; if (err !== 1'b0) $display("FAIL reset_err got=%b exp=0", err); else pass_cnt++;
      clr = 1'b0;
      $display("test_reset: q=%h dir=%b", q, dir);
   endtask

   task automatic test_up();
      clear_counts();
      ce = 1'b1;
      tick(2);
      for (int r = 0; r < 3; r++) begin
         drive(2'b10, 8); drive(2'b11, 8); drive(2'b01, 8); drive(2'b00, 8);
      end
      total_cnt++; if (q !== 16'd12) $display("FAIL up_q got=%h exp=000c", q); else pass_cnt++;
      total_cnt++; if (dir !== 1'b1) $display("FAIL up_dir got=%b exp=1", dir); else pass_cnt++;
      total_cnt++; if (step_cnt != 12) $display("FAIL up_steps got=%0d exp=12", step_cnt); else pass_cnt++;
      total_cnt++; if (err_cnt != 0) $display("FAIL up_err got=%0d exp=0", err_cnt); else pass_cnt++;
      $display("test_up: q=%h steps=%0d", q, step_cnt);
   endtask

   task automatic test_load_down();
      load = 1'b1; d = 16'h0001;
      tick(1);
      load = 1'b0;
      total_cnt++; if (q !== 16'h0001) $display("FAIL load_q got=%h exp=0001", q); else pass_cnt++;
      clear_counts();
      drive(2'b01, 8);
      total_cnt++; if (q !== 16'h0000) $display("FAIL down1_q got=%h exp=0000", q); else pass_cnt++;
      total_cnt++; if (wrap_cnt != 0) $display("FAIL down1_wrap got=%0d exp=0", wrap_cnt); else pass_cnt++;
      drive(2'b11, 8);
      total_cnt++; if (q !== 16'hFFFF) $display("FAIL down2_q got=%h exp=ffff", q); else pass_cnt++;
      total_cnt++; if (wrap_cnt != 1) $display("FAIL down2_wrap got=%0d exp=1", wrap_cnt); else pass_cnt++;
      drive(2'b10, 8);
      total_cnt++; if (q !== 16'hFFFE) $display("FAIL down3_q got=%h exp=fffe", q); else pass_cnt++;
      total_cnt++; if (wrap_cnt != 1) $display("FAIL down3_wrap got=%0d exp=1", wrap_cnt); else pass_cnt++;
      total_cnt++; if (dir !== 1'b0) $display("FAIL down_dir got=%b exp=0", dir); else pass_cnt++;
      total_cnt++; if (step_cnt != 3) $display("FAIL down_steps got=%0d exp=3", step_cnt); else pass_cnt++;
      $display("test_load_down: q=%h wraps=%0d", q, wrap_cnt);
   endtask

   task automatic test_illegal();
      drive(2'b00, 8);
      total_cnt++; if (q !== 16'hFFFD) $display("FAIL ill_pre_q got=%h exp=fffd", q); else pass_cnt++;
      clear_counts();
      drive(2'b11, 8);
      total_cnt++; if (err_cnt != 1) $display("FAIL ill_err got=%0d exp=1", err_cnt); else pass_cnt++;
      total_cnt++; if (q !== 16'hFFFD) $display("FAIL ill_q got=%h exp=fffd", q); else pass_cnt++;
      total_cnt++; if (step_cnt != 0) $display("FAIL ill_steps got=%0d exp=0", step_cnt); else pass_cnt++;
      clear_counts();
      drive(2'b01, 8);
      total_cnt++; if (q !== 16'hFFFE) $display("FAIL ill_next_q got=%h exp=fffe", q); else pass_cnt++;
      total_cnt++; if (dir !== 1'b1) $display("FAIL ill_next_dir got=%b exp=1", dir); else pass_cnt++;
      total_cnt++; if (step_cnt != 1) $display("FAIL ill_next_steps got=%0d exp=1", step_cnt); else pass_cnt++;
      $display("test_illegal: q=%h", q);
   endtask

   task automatic test_ce();
      ce = 1'b0;
      clear_counts();
      drive(2'b00, 8); drive(2'b10, 8); drive(2'b11, 8); drive(2'b01, 8); drive(2'b00, 8);
      total_cnt++; if (q !== 16'hFFFE) $display("FAIL ce0_q got=%h exp=fffe", q); else pass_cnt++;
      total_cnt++; if (step_cnt != 0) $display("FAIL ce0_steps got=%0d exp=0", step_cnt); else pass_cnt++;
      ce = 1'b1;
      drive(2'b10, 8); drive(2'b11, 8);
      total_cnt++; if (q !== 16'h0000) $display("FAIL ce1_q got=%h exp=0000", q); else pass_cnt++;
      total_cnt++; if (step_cnt != 2) $display("FAIL ce1_steps got=%0d exp=2", step_cnt); else pass_cnt++;
      total_cnt++; if (wrap_cnt != 1) $display("FAIL ce1_wrap got=%0d exp=1", wrap_cnt); else pass_cnt++;
      $display("test_ce: q=%h steps=%0d", q, step_cnt);
   endtask

   task automatic test_load_step();
      clear_counts();
      a_in = 1'b0; b_in = 1'b1;
      tick(LAT);
      load = 1'b1; d = 16'h0100;
      tick(1);
      load = 1'b0;
      tick(6);
      total_cnt++; if (q !== 16'h0100) $display("FAIL ldstep_q got=%h exp=0100", q); else pass_cnt++;
      total_cnt++; if (step_cnt != 0) $display("FAIL ldstep_steps got=%0d exp=0", step_cnt); else pass_cnt++;
      drive(2'b00, 8);
      total_cnt++; if (q !== 16'h0101) $display("FAIL ldstep_next_q got=%h exp=0101", q); else pass_cnt++;
      total_cnt++; if (step_cnt != 1) $display("FAIL ldstep_next_steps got=%0d exp=1", step_cnt); else pass_cnt++;
      $display("test_load_step: q=%h", q);
   endtask

   task automatic test_back_to_back();
      clear_counts();
      drive(2'b10, FAST); drive(2'b11, FAST); drive(2'b01, FAST);
      tick(LAT + 4);
      total_cnt++; if (q !== 16'h0104) $display("FAIL b2b_q got=%h exp=0104", q); else pass_cnt++;
      total_cnt++; if (step_cnt != 3) $display("FAIL b2b_steps got=%0d exp=3", step_cnt); else pass_cnt++;
      $display("test_back_to_back: q=%h steps=%0d", q, step_cnt);
   endtask

   task automatic test_clr_mid();
      drive(2'b00, 8);
      total_cnt++; if (q !== 16'h0105) $display("FAIL clr_pre_q got=%h exp=0105", q); else pass_cnt++;
      clr = 1'b1;
      tick(2);
      total_cnt++; if (q !== 16'h0000) $display("FAIL clr_q got=%h exp=0000", q); else pass_cnt++;
      clr = 1'b0;
      clear_counts();
      tick(6);
      total_cnt++; if (step_cnt != 0) $display("FAIL clr_spurious got=%0d exp=0", step_cnt); else pass_cnt++;
      drive(2'b10, 8);
      total_cnt++; if (q !== 16'h0001) $display("FAIL clr_next_q got=%h exp=0001", q); else pass_cnt++;
      total_cnt++; if (step_cnt != 1) $display("FAIL clr_next_steps got=%0d exp=1", step_cnt); else pass_cnt++;
      $display("test_clr_mid: q=%h", q);
   endtask

`ifdef QDEC_FILTER_EN
   task automatic test_filter();
      clear_counts();
      a_in = 1'b0;
      tick(2);
      a_in = 1'b1;
      tick(10);
      total_cnt++; if (q !== 16'h0001) $display("FAIL glitch_q got=%h exp=0001", q); else pass_cnt++;
      total_cnt++; if (step_cnt != 0) $display("FAIL glitch_steps got=%0d exp=0", step_cnt); else pass_cnt++;
      a_in = 1'b0;
      tick(LAT);
      total_cnt++; if (q !== 16'h0001) $display("FAIL filt_early_q got=%h exp=0001", q); else pass_cnt++;
      tick(1);
      total_cnt++; if (q !== 16'h0000) $display("FAIL filt_q got=%h exp=0000", q); else pass_cnt++;
      total_cnt++; if (step_cnt != 1) $display("FAIL filt_steps got=%0d exp=1", step_cnt); else pass_cnt++;
      $display("test_filter: q=%h", q);
   endtask
`endif

   initial begin
      test_reset();
      test_up();
      test_load_down();
      test_illegal();
      test_ce();
      test_load_step();
      test_back_to_back();
      test_clr_mid();
`ifdef QDEC_FILTER_EN
      test_filter();
`endif
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
